// File: rtl/write_buffered_memory.sv
// rtl/write_buffered_memory.sv - posted-write memory responder with in-order drain FSM; MEM_WB_FORWARD_EN enables FIFO read forwarding
module write_buffered_memory #(
   parameter int ADDR_W    = 5,
   parameter int DATA_W    = 16,
   parameter int DEPTH     = 4,
   parameter int WRITE_LAT = 3
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   readwriteN,
   input  logic [ADDR_W-1:0]      address,
   input  logic [DATA_W-1:0]      data_in,
   output logic [DATA_W-1:0]      data_out,
   output logic [$clog2(DEPTH):0] buf_count,
   output logic                   busy,
   output logic                   overflow
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(WRITE_LAT + 1);
   localparam int WORDS = 2 ** ADDR_W;

   localparam logic [CNT_W-1:0] LAT_FULL = CNT_W'(WRITE_LAT);
   localparam logic [CNT_W-1:0] LAT_REST = CNT_W'(WRITE_LAT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [PTR_W:0]   OCC_ONE  = (PTR_W + 1)'(1);
   localparam logic [PTR_W:0]   OCC_FULL = (PTR_W + 1)'(DEPTH);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t            state;
   state_t            next_state;
   logic [CNT_W-1:0]  cnt;
   logic [CNT_W-1:0]  next_cnt;
   logic              pop;
   logic              push;
   logic              full;
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W-1:0]  wr_ptr;
   logic [ADDR_W-1:0] fifo_addr [DEPTH];
   logic [DATA_W-1:0] fifo_data [DEPTH];
   logic [DATA_W-1:0] mem [WORDS];
   logic [DATA_W-1:0] read_value;

   assign full = (buf_count == OCC_FULL);
   // a full FIFO still accepts a write on the edge its head is committed
   assign push = readwriteN && (!full || pop);
   assign busy = (state == BUSY);

   // cnt counts edges left in the head's service window, commit edge included;
   // the IDLE edge that notices a waiting entry is the window's first edge
   always_comb begin
      next_state = state;
      next_cnt   = cnt;
      pop        = 1'b0;
      case (state)
         IDLE: begin
            if (buf_count != '0) begin
               if (WRITE_LAT == 1) begin
                  pop = 1'b1;
                  if (buf_count > OCC_ONE || readwriteN) begin
                     next_state = BUSY;
                     next_cnt   = LAT_FULL;
                  end
               end else begin
                  next_state = BUSY;
                  next_cnt   = LAT_REST;
               end
            end
         end
         BUSY: begin
            if (cnt == CNT_ONE) begin
               pop = 1'b1;
               // an entry pushed on the commit edge counts as remaining
               if (buf_count > OCC_ONE || readwriteN) begin
                  next_cnt = LAT_FULL;
               end else begin
                  next_state = IDLE;
               end
            end else begin
               next_cnt = cnt - 1'b1;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // drain FSM state and service counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= next_state;
         cnt   <= next_cnt;
      end
   end

   // FIFO pointers, occupancy and sticky overflow flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         buf_count <= '0;
         overflow  <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   buf_count <= buf_count + 1'b1;
            2'b01:   buf_count <= buf_count - 1'b1;
            default: buf_count <= buf_count;
         endcase
         if (readwriteN && !push) overflow <= 1'b1;
      end
   end

   // FIFO payload storage; contents are meaningless outside the occupied window
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_addr[wr_ptr] <= address;
         fifo_data[wr_ptr] <= data_in;
      end
   end

   // slow array: the FIFO head is written on its commit edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < WORDS; i++) mem[i] <= '0;
      end else if (pop) begin
         mem[fifo_addr[rd_ptr]] <= fifo_data[rd_ptr];
      end
   end

   // read source: youngest occupied FIFO match wins over the array
   always_comb begin
      read_value = mem[address];
`ifdef MEM_WB_FORWARD_EN
      for (int i = 0; i < DEPTH; i++) begin
         if (((PTR_W + 1)'(i) < buf_count) &&
             (fifo_addr[rd_ptr + PTR_W'(i)] == address)) begin
            read_value = fifo_data[rd_ptr + PTR_W'(i)];
         end
      end
`endif
   end

   // registered read data; writes leave it untouched
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_out <= '0;
      end else if (!readwriteN) begin
         data_out <= read_value;
      end
   end

endmodule
